// File: rtl/wb_master_standard_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone block master: bus widths, counter
// widths, the master FSM state encoding and an address-increment helper.
// No ports (package).
// ----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_ADR_W  = 16;
  localparam int WB_DAT_W  = 16;
  localparam int CMD_LEN_W = 8;
  localparam int TMO_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WFETCH = 3'd1,
    ST_BUS    = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } wb_state_t;

  // Word address advance; 0xFFFF rolls over to 0x0000 by plain truncation.
  function automatic logic [WB_ADR_W-1:0] adr_inc(input logic [WB_ADR_W-1:0] a);
    return a + WB_ADR_W'(1);
  endfunction

endpackage

// File: rtl/wb_master_standard_if.sv
// ----------------------------------------------------------------------------
// if_wb
// Wishbone classic bus bundle carrying the clock and synchronous reset.
// Ports : clk (in), rst (in, synchronous active-high)
// Master modport drives cyc/stb/we/adr/dat_o and samples ack/dat_i.
// Slave modport drives ack/dat_i/stall. The master does not look at stall.
// ----------------------------------------------------------------------------
interface if_wb (
  input logic clk,
  input logic rst
);
  import wb_pkg::*;

  logic                cyc;
  logic                stb;
  logic                we;
  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_o;
  logic [WB_DAT_W-1:0] dat_i;
  logic                ack;
  logic                stall;

  modport master (
    input  clk, rst, ack, dat_i,
    output cyc, stb, we, adr, dat_o
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, dat_o,
    output ack, dat_i, stall
  );

endinterface

// File: rtl/wb_master_standard_timeout.sv
// ----------------------------------------------------------------------------
// wb_timeout
// Counts cycles a strobe has waited for ack.
// Ports : i_clk, i_rst   clock / synchronous active-high reset
//         i_load         clear the counter (held whenever not on the bus)
//         i_count        advance by one (bus cycle without ack)
//         o_expire       high during the cycle that would be the LIMIT-th
//                        unacknowledged strobe cycle
// ----------------------------------------------------------------------------
module wb_timeout #(
  parameter int unsigned LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);
  import wb_pkg::*;

  localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  // The counter holds k-1 during the k-th strobe cycle, so this flags the
  // cycle whose end would make the wait reach LIMIT.
  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/wb_master_standard.sv
// ----------------------------------------------------------------------------
// wb_master_standard
// Wishbone classic block master. Accepts a block command (read or write,
// start word address, beat count minus one) and runs it as single beats on
// the bus, with a per-beat ack timeout that aborts the rest of the block.
//
// Ports : wb          if_wb.master, carries clk/rst, cyc/stb/we/adr/dat_o,
//                     ack/dat_i
//         cmd_valid/cmd_ready, cmd_we, cmd_adr[15:0], cmd_len[7:0]
//         wdat_valid/wdat_ready, wdat[15:0]   write data stream
//         rdat_valid, rdat[15:0]              read data, no backpressure
//         done        one-cycle pulse when a block finishes or aborts
//         err         set on timeout abort, cleared at next command accept
//         dbg_state   current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid may rise without waiting for ready and, once raised, the
// payload is held until the transfer. rdat_valid has no ready and is a single
// cycle per beat.
// ----------------------------------------------------------------------------
module wb_master_standard
  import wb_pkg::*;
#(
  parameter int unsigned timeout = 16
) (
  if_wb.master                  wb,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [WB_ADR_W-1:0]   cmd_adr,
  input  logic [CMD_LEN_W-1:0]  cmd_len,
  input  logic                  wdat_valid,
  output logic                  wdat_ready,
  input  logic [WB_DAT_W-1:0]   wdat,
  output logic                  rdat_valid,
  output logic [WB_DAT_W-1:0]   rdat,
  output logic                  done,
  output logic                  err,
  output wb_state_t             dbg_state
);

  wb_state_t            r_state;
  logic                 r_cyc;
  logic                 r_stb;
  logic                 r_we;
  logic [WB_ADR_W-1:0]  r_adr;
  logic [WB_DAT_W-1:0]  r_dat_o;
  logic [CMD_LEN_W-1:0] r_cnt;
  logic                 r_cmd_ready;
  logic                 r_wdat_ready;
  logic                 r_rdat_valid;
  logic [WB_DAT_W-1:0]  r_rdat;
  logic                 r_done;
  logic                 r_err;

  logic w_in_bus;
  logic w_expire;

  assign w_in_bus = (r_state == ST_BUS);

  // Counter is held clear outside BUS, so every BUS entry starts from zero.
  wb_timeout #(
    .LIMIT (timeout)
  ) u_timeout (
    .i_clk    (wb.clk),
    .i_rst    (wb.rst),
    .i_load   (!w_in_bus),
    .i_count  (w_in_bus && !wb.ack),
    .o_expire (w_expire)
  );

  always_ff @(posedge wb.clk) begin
    if (wb.rst) begin
      r_state      <= ST_IDLE;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat_o      <= '0;
      r_cnt        <= '0;
      r_cmd_ready  <= 1'b1;
      r_wdat_ready <= 1'b0;
      r_rdat_valid <= 1'b0;
      r_rdat       <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rdat_valid <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_we        <= cmd_we;
            r_adr       <= cmd_adr;
            r_cnt       <= cmd_len;
            r_err       <= 1'b0;
            r_cyc       <= 1'b1;
            if (cmd_we) begin
              r_wdat_ready <= 1'b1;
              r_state      <= ST_WFETCH;
            end else begin
              r_stb   <= 1'b1;
              r_state <= ST_BUS;
            end
          end
        end
        ST_WFETCH: begin
          if (wdat_valid) begin
            r_dat_o      <= wdat;
            r_wdat_ready <= 1'b0;
            r_stb        <= 1'b1;
            r_state      <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack is tested before the timeout so a last-cycle ack still succeeds.
          if (wb.ack) begin
            r_stb <= 1'b0;
            if (!r_we) begin
              r_rdat       <= wb.dat_i;
              r_rdat_valid <= 1'b1;
            end
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CMD_LEN_W'(1);
              r_adr <= adr_inc(r_adr);
              if (r_we) begin
                r_wdat_ready <= 1'b1;
                r_state      <= ST_WFETCH;
              end else begin
                r_state <= ST_GAP;
              end
            end else begin
              r_cyc   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else if (w_expire) begin
            r_err   <= 1'b1;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_GAP: begin
          r_stb   <= 1'b1;
          r_state <= ST_BUS;
        end
        ST_DONE: begin
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_cyc       <= 1'b0;
          r_stb       <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb.cyc   = r_cyc;
  assign wb.stb   = r_stb;
  assign wb.we    = r_we;
  assign wb.adr   = r_adr;
  assign wb.dat_o = r_dat_o;

  // Gated with reset so commands are refused for as long as reset is held.
  assign cmd_ready  = r_cmd_ready && !wb.rst;
  assign wdat_ready = r_wdat_ready;
  assign rdat_valid = r_rdat_valid;
  assign rdat       = r_rdat;
  assign done       = r_done;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: doc/wb_master_standard.md
WB_MASTER_STANDARD -- requirements
Module: wb_master_standard

Interface
REQ-001 Parameter timeout, default 16: maximum cycles stb may stay high awaiting ack before the beat is aborted; legal range 2..255.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 wb.clk  input  1  clock, carried in if_wb; all logic on rising edge.
REQ-004 wb.rst  input  1  synchronous active-high reset, carried in if_wb.
REQ-005 wb  if_wb.master  --  Wishbone classic port: drives cyc, stb, we, adr[15:0], dat_o[15:0]; samples ack and dat_i[15:0]; ignores stall.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-008 cmd_we  input  1  1 = write block, 0 = read block.
REQ-009 cmd_adr  input  16  start word address.
REQ-010 cmd_len  input  8  beat count minus one (1..256 beats).
REQ-011 wdat_valid / wdat_ready / wdat  input / output / input 16  write-data stream.
REQ-012 rdat_valid / rdat  output 1 / output 16  read-data stream; no backpressure.
REQ-013 done  output  1  one-cycle pulse at block end; err  output  1  abort flag.

Function
REQ-014 States: IDLE, WFETCH, BUS, GAP, DONE.
REQ-015 IDLE: cmd_ready = 1, cyc = stb = 0; on accept, latch we, adr and beat counter = cmd_len; go WFETCH if write, else BUS; err cleared at accept.
REQ-016 cmd_ready SHALL be 0 in every state other than IDLE.
REQ-017 WFETCH: cyc = 1, stb = 0, wdat_ready = 1; on wdat_valid, capture wdat into holding register and go BUS; waits indefinitely.
REQ-018 BUS: cyc = stb = 1, we = latched we, adr = current address, dat_o = holding register; we, adr and dat_o SHALL stay stable until ack.
REQ-019 On ack in BUS: for reads, rdat_valid = 1 with rdat = dat_i in the following cycle (one-cycle registered latency).
REQ-019a On ack in BUS with beats remaining: decrement counter, increment adr by 1 (0xFFFF wraps to 0x0000), go GAP (read) or WFETCH (write).
REQ-020 On ack of the last beat: go DONE.
REQ-021 GAP: cyc = 1, stb = 0 for exactly one cycle, then BUS.
REQ-022 cyc SHALL remain high from the first BUS cycle until the last ack or abort, including WFETCH and GAP.
REQ-023 DONE: cyc = stb = 0, done = 1 for one cycle, then IDLE.
REQ-024 Timeout: cycle counter cleared on BUS entry, increments each BUS cycle without ack.
REQ-024a On reaching timeout without ack: set err, drop cyc/stb next cycle, discard remaining beats, consume no further wdat, go DONE.
REQ-025 Ack arriving in the same cycle the counter reaches timeout SHALL count as success (ack wins).
REQ-026 ack sampled outside BUS SHALL be ignored.
REQ-027 wdat_ready SHALL be 0 outside WFETCH; rdat_valid SHALL be 0 except as in REQ-019.

Reset
REQ-028 While wb.rst is sampled high: state = IDLE; cyc, stb, we, done, err, rdat_valid, wdat_ready = 0; adr, dat_o, rdat = 0.
REQ-028a While wb.rst is sampled high: cmd_ready = 0; cmd_ready = 1 in the first cycle after wb.rst deasserts.
REQ-029 Reset mid-block SHALL drop cyc/stb on the next edge with no done pulse and no rdat_valid.

Structure
REQ-030 Shared package wb_pkg SHALL hold the state enum and constants WB_ADR_W = 16, WB_DAT_W = 16.
REQ-031 Optional sub-module wb_timeout (load, count, expire) is natural; everything else stays in wb_master_standard.

Verification
REQ-032 Read cmd_adr = 0x0010, cmd_len = 3 against wb_slave_standard (waitcycles = 0), RAM preloaded 0xA0..0xA3 -> adr 0x10..0x13; rdat 0xA0,0xA1,0xA2,0xA3; cyc high 11 cycles; done 1 cycle after the last ack.
REQ-033 Write cmd_adr = 0xFFFE, cmd_len = 2, wdat 0x1111, 0x2222, 0x3333 (one wdat_valid gap cycle each) -> addresses 0xFFFE, 0xFFFF, 0x0000 written; readback matches; err = 0.
REQ-034 Slave never acks, timeout = 16 -> stb high exactly 16 cycles; err = 1, done pulse; cyc = 0 afterward; remaining wdat not consumed.
REQ-035 Slave waitcycles = 3, single read -> stb high 5 cycles; rdat_valid 1 cycle after ack; ack arriving in the timeout cycle gives err = 0.
REQ-036 Assert wb.rst during the second beat of a 4-beat read -> cyc/stb = 0 next cycle, no done, no rdat_valid; next command runs normally.
